psm_carrier_ctrl: RTL
=====================

Name: psm_carrier_ctrl

Overview:
Sequencer for the PSM deadtime stage. Generates the PSM square-wave carrier consumed by the deadtime generators from a programmable half-period. Owns the gate-enable sequencing: bootstrap precharge, run, graceful stop and fault latch-off. Applies frequency and deadtime updates glitch-free, only at period boundaries.

Parameters:
BITS_DATA, 16, width of iFREQUENCY (half-period in CLK cycles)
DEADTIME_BITS_DATA, 8, width of iDEADTIME/oDEADTIME
BOOT_CYCLES, 64, length of bootstrap precharge in START (CLK cycles, >=1)
SS_PERIODS, 16, number of soft-start periods (used only with the optional feature)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
iEN  in  1  level run request
iFAULT  in  1  level fault input, highest priority
iFAULT_CLR  in  1  one-cycle pulse, clears fault latch
iUPDATE  in  1  one-cycle pulse, captures iFREQUENCY/iDEADTIME
iFREQUENCY  in  BITS_DATA  requested half-period, CLK cycles
iDEADTIME  in  DEADTIME_BITS_DATA  requested deadtime, CLK cycles
oPSM  out  1  carrier to the deadtime stage
oDEADTIME  out  DEADTIME_BITS_DATA  active deadtime to the deadtime stage
oGATE_EN  out  1  gate-driver enable
oSYNC  out  1  one-cycle pulse on each oPSM 0->1 edge
oSTATE  out  3  IDLE=0, START=1, RUN=2, STOP=3, FAULT=4
oCFG_ERR  out  1  last update was rejected (sticky)

Behaviour:
- Reset (RST=0, asynchronous): state IDLE. All outputs 0. Active and pending config = 0. Pending flag cleared.
- Config validity: iFREQUENCY >= 2 and iFREQUENCY > iDEADTIME+1. Compare with zero-extension to max width.
- iUPDATE, valid config: capture into pending and clear oCFG_ERR.
- iUPDATE, invalid config: pending unchanged, oCFG_ERR<=1. oCFG_ERR stays set until the next valid update.
- Applying pending: immediately (next clock) in IDLE/FAULT. In RUN/STOP it is applied on the clock where oPSM goes 0->1, and the new half-period takes effect from that high half. oDEADTIME always reflects the active config.
- Half-period counter cnt runs 0..hp-1. At cnt==hp-1: toggle oPSM and set cnt<=0.
- IDLE: oPSM=0, oGATE_EN=0. If iEN=1 and active config is valid, go to START next clock. If iEN=1 and config is invalid, stay in IDLE.
- START: oGATE_EN=1, oPSM=0 (low side on for bootstrap). After BOOT_CYCLES clocks, go to RUN with oPSM<=1, cnt<=0, oSYNC=1. If iEN=0 in START, return to IDLE next clock with oGATE_EN=0.
- RUN: free-running carrier with 50% duty and period 2*hp. oSYNC=1 on the same clock oPSM first reads 1. If iEN=0, go to STOP without altering the current counter.
- STOP: counter keeps running. At terminal count with oPSM=1: oPSM<=0, stay in STOP. At terminal count with oPSM=0: go to IDLE with oGATE_EN<=0. The output therefore always ends with a complete low half-period and no new rising edge occurs. iEN reasserted during STOP is ignored; IDLE re-evaluates it.
- FAULT: iFAULT=1 in any state takes effect on the next clock: oPSM=0, oGATE_EN=0, cnt=0, oSYNC=0. Exit to IDLE only when iFAULT=0 and iFAULT_CLR=1 in the same cycle. iFAULT_CLR is ignored while iFAULT=1.
- Priority order: iFAULT > iEN drop > terminal count > iUPDATE apply.
- iUPDATE coinciding with an apply edge: the previous pending value applies. The new value becomes pending.

Optional Feature:
PSM_SOFTSTART_EN: when defined, the first SS_PERIODS full periods after START->RUN use an effective half-period of 2*hp (internal width BITS_DATA+1), then switch to hp at a 0->1 edge. A soft-start period counter gates the switch; it resets on entry to RUN. When not defined, RUN uses hp from the first edge and no soft-start logic is synthesized.

Test Plan:
1. Reset; iUPDATE with iFREQUENCY=20, iDEADTIME=1; iEN=1 -> oSTATE=1 with oGATE_EN=1 and oPSM=0 for 64 clocks. Then oPSM runs 20 high / 20 low, oSYNC every 40 clocks, oDEADTIME=1.
2. In RUN at hp=20, iUPDATE iFREQUENCY=10 at cnt=5 of the high half -> current period completes 20/20. The next period is 10/10, with oSYNC coincident with the change.
3. iFAULT=1 mid-high-half -> next clock oPSM=0, oGATE_EN=0, oSTATE=4. iFAULT_CLR with iFAULT=1 -> stays in FAULT. iFAULT=0 plus iFAULT_CLR -> IDLE.
4. iEN=0 at cnt=5 of the high half -> 15 more high clocks, then 20 low clocks, then IDLE with oGATE_EN=0 and no extra rising edge.
5. iUPDATE iFREQUENCY=5, iDEADTIME=8 -> oCFG_ERR=1, carrier unchanged. From reset with no valid update, iEN=1 -> remains IDLE.
6. With PSM_SOFTSTART_EN, hp=20, SS_PERIODS=16 -> 16 periods of 40/40, then 20/20.

Source files
------------

// File: rtl/psm_carrier_ctrl.sv
// -----------------------------------------------------------------------------
// psm_carrier_ctrl
//
// Sequencer for the PSM deadtime stage. It produces the square-wave carrier
// (oPSM) from a programmable half-period. It also owns gate-enable sequencing:
// bootstrap precharge, run, graceful stop, and fault latch-off. Frequency and
// deadtime changes are staged in a pending register. They reach the active
// configuration only at period boundaries, so the carrier never glitches.
//
// Optional build macro: PSM_SOFTSTART_EN
//   When defined, the first SS_PERIODS periods after START->RUN run at twice
//   the programmed half-period.
//
// Ports
//   CLK          system clock
//   RST          asynchronous, active-low reset
//   iEN          level run request
//   iFAULT       level fault input, highest priority
//   iFAULT_CLR   pulse, clears the fault latch (only while iFAULT=0)
//   iUPDATE      pulse, captures iFREQUENCY/iDEADTIME into the pending config
//   iFREQUENCY   requested half-period in CLK cycles
//   iDEADTIME    requested deadtime in CLK cycles
//   oPSM         carrier to the deadtime stage
//   oDEADTIME    active deadtime
//   oGATE_EN     gate-driver enable
//   oSYNC        one-cycle pulse with every oPSM 0->1 edge
//   oSTATE       IDLE=0, START=1, RUN=2, STOP=3, FAULT=4
//   oCFG_ERR     sticky flag, set when the last update was rejected
// -----------------------------------------------------------------------------
module psm_carrier_ctrl #(
  parameter int BITS_DATA          = 16,
  parameter int DEADTIME_BITS_DATA = 8,
  parameter int BOOT_CYCLES        = 64,
  parameter int SS_PERIODS         = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          iEN,
  input  logic                          iFAULT,
  input  logic                          iFAULT_CLR,
  input  logic                          iUPDATE,
  input  logic [BITS_DATA-1:0]          iFREQUENCY,
  input  logic [DEADTIME_BITS_DATA-1:0] iDEADTIME,
  output logic                          oPSM,
  output logic [DEADTIME_BITS_DATA-1:0] oDEADTIME,
  output logic                          oGATE_EN,
  output logic                          oSYNC,
  output logic [2:0]                    oSTATE,
  output logic                          oCFG_ERR
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // The compare width is one bit wider than either operand, so deadtime+1
  // cannot wrap.
  localparam int CMP_W  = ((BITS_DATA > DEADTIME_BITS_DATA) ? BITS_DATA : DEADTIME_BITS_DATA) + 1;
  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  // A single counter times both the bootstrap precharge and the carrier halves.
  localparam int CNT_W  = (BOOT_W > BITS_DATA + 1) ? BOOT_W : BITS_DATA + 1;

  function automatic logic cfg_valid(input logic [BITS_DATA-1:0]          f,
                                     input logic [DEADTIME_BITS_DATA-1:0] d);
    logic [CMP_W-1:0] fz;
    logic [CMP_W-1:0] dz;
    fz = CMP_W'(f);
    dz = CMP_W'(d);
    return (fz >= CMP_W'(2)) && (fz > dz + CMP_W'(1));
  endfunction

  state_t                          state, state_n;
  logic [CNT_W-1:0]                cnt, cnt_n;
  logic                            psm, psm_n;
  logic                            gate, gate_n;
  logic                            sync, sync_n;
  logic [BITS_DATA-1:0]            act_hp, pend_hp;
  logic [DEADTIME_BITS_DATA-1:0]   act_dt, pend_dt;
  logic                            pend_flag;
  logic                            cfg_err;
  logic                            apply;
  logic                            upd_ok;
  logic                            tc;
  logic [BITS_DATA:0]              eff_hp;

  assign upd_ok = iUPDATE && cfg_valid(iFREQUENCY, iDEADTIME);

`ifdef PSM_SOFTSTART_EN
  localparam int SS_W = (SS_PERIODS < 1) ? 1 : $clog2(SS_PERIODS + 1);
  logic [SS_W-1:0] ss_cnt, ss_cnt_n;
  logic            in_ss;

  assign in_ss  = (ss_cnt < SS_W'(SS_PERIODS));
  assign eff_hp = in_ss ? {act_hp, 1'b0} : {1'b0, act_hp};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ss_cnt <= '0;
    else      ss_cnt <= ss_cnt_n;
  end
`else
  assign eff_hp = {1'b0, act_hp};
`endif

  // Terminal count of the current half-period.
  assign tc = (cnt == CNT_W'(eff_hp) - CNT_W'(1));

  // NOTE: every signal written here receives a default first, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    psm_n   = psm;
    gate_n  = gate;
    sync_n  = 1'b0;
    apply   = pend_flag && ((state == S_IDLE) || (state == S_FAULT));
`ifdef PSM_SOFTSTART_EN
    ss_cnt_n = ss_cnt;
`endif
    if (iFAULT) begin
      state_n = S_FAULT;
      cnt_n   = '0;
      psm_n   = 1'b0;
      gate_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_n  = '0;
          psm_n  = 1'b0;
          gate_n = 1'b0;
          if (iEN && cfg_valid(act_hp, act_dt)) begin
            state_n = S_START;
            gate_n  = 1'b1;
          end
        end
        S_START: begin
          if (!iEN) begin
            state_n = S_IDLE;
            gate_n  = 1'b0;
            cnt_n   = '0;
          end else if (cnt == CNT_W'(BOOT_CYCLES - 1)) begin
            // The first rising edge is a period boundary, like any later one.
            state_n = S_RUN;
            psm_n   = 1'b1;
            sync_n  = 1'b1;
            cnt_n   = '0;
            apply   = pend_flag;
`ifdef PSM_SOFTSTART_EN
            ss_cnt_n = '0;
`endif
          end
        end
        S_RUN, S_STOP: begin
          // Dropping iEN outranks the terminal count on the same clock, so a
          // pending low->high toggle becomes the end of the run instead.
          if ((state == S_RUN) && !iEN) state_n = S_STOP;
          if (tc) begin
            cnt_n = '0;
            if (psm) begin
              psm_n = 1'b0;
            end else if (state_n == S_STOP) begin
              state_n = S_IDLE;
              gate_n  = 1'b0;
            end else begin
              psm_n  = 1'b1;
              sync_n = 1'b1;
              apply  = pend_flag;
`ifdef PSM_SOFTSTART_EN
              if (in_ss) ss_cnt_n = ss_cnt + SS_W'(1);
`endif
            end
          end
        end
        S_FAULT: begin
          cnt_n = '0;
          if (iFAULT_CLR) state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
          psm_n   = 1'b0;
          gate_n  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // here samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      psm       <= 1'b0;
      gate      <= 1'b0;
      sync      <= 1'b0;
      act_hp    <= '0;
      act_dt    <= '0;
      pend_hp   <= '0;
      pend_dt   <= '0;
      pend_flag <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      psm   <= psm_n;
      gate  <= gate_n;
      sync  <= sync_n;
      // Apply reads the old pending value. An update on the same clock
      // becomes the next pending value.
      if (apply) begin
        act_hp <= pend_hp;
        act_dt <= pend_dt;
      end
      if (upd_ok) begin
        pend_hp   <= iFREQUENCY;
        pend_dt   <= iDEADTIME;
        pend_flag <= 1'b1;
        cfg_err   <= 1'b0;
      end else begin
        if (apply)   pend_flag <= 1'b0;
        if (iUPDATE) cfg_err   <= 1'b1;
      end
    end
  end

  assign oPSM      = psm;
  assign oDEADTIME = act_dt;
  assign oGATE_EN  = gate;
  assign oSYNC     = sync;
  assign oSTATE    = state;
  assign oCFG_ERR  = cfg_err;

endmodule
